f_pc_ctrl: RTL and testbench

Fetch-stage PC sequencer for the pipelined MIPS core.
- Owns the architectural fetch PC register and the instruction-memory request handshake.
- Arbitrates redirect sources: exception entry, `eret`, the taken branch/jump target resolved in D, and sequential +4.
- Buffers a redirect that arrives while a fetch is outstanding, so one-cycle redirect pulses are never lost.
- Sits between the D-stage next-PC logic, the M-stage CP0 outputs, and the instruction memory port.

---
 rtl/f_pc_ctrl.sv | 137 +++++++++++++
 tb/tb_f_pc_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC sequencer: owns pc_F, the imem request, and buffering of redirects
// that arrive while a fetch is outstanding. Optional macro PC_RANGE_CHECK_EN adds a range check to adel_F.
module f_pc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        d_redirect,
  input  logic [31:0] d_target,
  input  logic        imem_ack,
  output logic [31:0] pc_F,
  output logic        fetch_req,
  output logic        kill_F,
  output logic        adel_F,
  output logic        pend_F
);

  // Handshake: fetch_req is held high outside reset; the word for pc_F is
  // transferred on an edge where imem_ack=1, and pc_F only moves on such an edge.

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  // Encoding doubles as priority: a larger value beats a smaller one.
  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_DRED = 2'd1,
    K_ERET = 2'd2,
    K_EXC  = 2'd3
  } kind_t;

  state_t      state, state_next;
  kind_t       slot_kind, slot_kind_next;
  logic [31:0] slot_target, slot_target_next;
  logic [31:0] pc_next;

  kind_t       ev_kind;
  logic [31:0] ev_target;
  kind_t       win_kind;
  logic [31:0] win_target;

  // Same-cycle event arbitration; stall only masks the D-stage redirect.
  always_comb begin
    ev_kind   = K_NONE;
    ev_target = 32'h0;
    if (exc_req) begin
      ev_kind   = K_EXC;
      ev_target = EXC_ENTRY;
    end else if (eret) begin
      ev_kind   = K_ERET;
      ev_target = epc;
    end else if (d_redirect && !stall) begin
      ev_kind   = K_DRED;
      ev_target = d_target;
    end
  end

  // Strictly higher priority displaces the slot; ties keep the older entry.
  always_comb begin
    win_kind   = slot_kind;
    win_target = slot_target;
    if (ev_kind > slot_kind) begin
      win_kind   = ev_kind;
      win_target = ev_target;
    end
  end

  always_comb begin
    state_next       = state;
    slot_kind_next   = slot_kind;
    slot_target_next = slot_target;
    pc_next          = pc_F;
    kill_F           = 1'b0;
    unique case (state)
      RUN: begin
        if (imem_ack) begin
          if (ev_kind != K_NONE) begin
            pc_next = ev_target;
            kill_F  = (ev_kind == K_EXC) || (ev_kind == K_ERET);
          end else if (!stall) begin
            pc_next = pc_F + 32'd4;
          end
        end else if (ev_kind != K_NONE) begin
          state_next       = PEND;
          slot_kind_next   = ev_kind;
          slot_target_next = ev_target;
        end
      end
      PEND: begin
        if (imem_ack) begin
          pc_next          = win_target;
          kill_F           = (win_kind == K_EXC) || (win_kind == K_ERET);
          state_next       = RUN;
          slot_kind_next   = K_NONE;
          slot_target_next = 32'h0;
        end else begin
          slot_kind_next   = win_kind;
          slot_target_next = win_target;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      slot_kind   <= K_NONE;
      slot_target <= 32'h0;
      pc_F        <= RESET_PC;
    end else begin
      state       <= state_next;
      slot_kind   <= slot_kind_next;
      slot_target <= slot_target_next;
      pc_F        <= pc_next;
    end
  end

  assign fetch_req = ~reset;
  assign pend_F    = (state == PEND);

`ifdef PC_RANGE_CHECK_EN
  assign adel_F = (pc_F[1:0] != 2'b00) || (pc_F < 32'h0000_3000) || (pc_F > 32'h0000_6FFC);
`else
  assign adel_F = (pc_F[1:0] != 2'b00);
`endif

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Directed bench for f_pc_ctrl: sequential fetch, stalls, buffered and immediate
// redirects, async reset mid-pending, alignment/range errors and PC wrap.
module tb_f_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic        d_redirect;
  logic [31:0] d_target;
  logic        imem_ack;
  logic [31:0] pc_F;
  logic        fetch_req;
  logic        kill_F;
  logic        adel_F;
  logic        pend_F;

  int err_cnt = 0;
  int chk_cnt = 0;

  f_pc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .exc_req    (exc_req),
    .eret       (eret),
    .epc        (epc),
    .d_redirect (d_redirect),
    .d_target   (d_target),
    .imem_ack   (imem_ack),
    .pc_F       (pc_F),
    .fetch_req  (fetch_req),
    .kill_F     (kill_F),
    .adel_F     (adel_F),
    .pend_F     (pend_F)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic range_en;

  initial begin
`ifdef PC_RANGE_CHECK_EN
    range_en = 1'b1;
`else
    range_en = 1'b0;
`endif
    reset = 1'b1; stall = 1'b0; exc_req = 1'b0; eret = 1'b0; epc = 32'h0;
    d_redirect = 1'b0; d_target = 32'h0; imem_ack = 1'b1;
    #3;
    check("rst_pc", pc_F, 32'h0000_3000);
    check("rst_req", {31'h0, fetch_req}, 32'd0);
    check("rst_pend", {31'h0, pend_F}, 32'd0);
    check("rst_kill", {31'h0, kill_F}, 32'd0);
    tick();
    #1 reset = 1'b0;
    #1;
    check("req_after_rel", {31'h0, fetch_req}, 32'd1);
    check("seq_pc0", pc_F, 32'h0000_3000);
    check("seq_kill0", {31'h0, kill_F}, 32'd0);
    tick();
    check("seq_pc1", pc_F, 32'h0000_3004);
    tick();
    check("seq_pc2", pc_F, 32'h0000_3008);
    check("seq_kill2", {31'h0, kill_F}, 32'd0);

    // Stalled D redirect must neither redirect nor advance.
    d_redirect = 1'b1; d_target = 32'h0000_3100; stall = 1'b1;
    #1 check("dred_stall_kill", {31'h0, kill_F}, 32'd0);
    tick();
    check("dred_stall_pc", pc_F, 32'h0000_3008);
    stall = 1'b0;
    #1 check("dred_kill", {31'h0, kill_F}, 32'd0);
    tick();
    check("dred_pc", pc_F, 32'h0000_3100);
    d_redirect = 1'b0;

    // Exception pulse while memory is busy: buffered until the ack.
    imem_ack = 1'b0; exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    check("exc_pend1", {31'h0, pend_F}, 32'd1);
    check("exc_hold1", pc_F, 32'h0000_3100);
    tick();
    tick();
    check("exc_pend3", {31'h0, pend_F}, 32'd1);
    check("exc_hold3", pc_F, 32'h0000_3100);
    imem_ack = 1'b1;
    #1 check("exc_kill", {31'h0, kill_F}, 32'd1);
    tick();
    check("exc_pc", pc_F, 32'h0000_4180);
    check("exc_pend_clr", {31'h0, pend_F}, 32'd0);
    check("exc_kill_after", {31'h0, kill_F}, 32'd0);

    // Pending D redirect displaced by a later eret.
    imem_ack = 1'b0; d_redirect = 1'b1; d_target = 32'h0000_3200;
    tick();
    d_redirect = 1'b0;
    check("dred_pend", {31'h0, pend_F}, 32'd1);
    eret = 1'b1; epc = 32'h0000_3050;
    tick();
    eret = 1'b0;
    check("eret_pend_hold", pc_F, 32'h0000_4180);
    imem_ack = 1'b1;
    #1 check("eret_kill", {31'h0, kill_F}, 32'd1);
    tick();
    check("eret_pc", pc_F, 32'h0000_3050);
    check("eret_pend_clr", {31'h0, pend_F}, 32'd0);

    // Pending exception must not be displaced by a D redirect.
    imem_ack = 1'b0; exc_req = 1'b1;
    tick();
    exc_req = 1'b0; d_redirect = 1'b1; d_target = 32'h0000_3300;
    tick();
    d_redirect = 1'b0; imem_ack = 1'b1;
    #1 check("exc_over_dred_kill", {31'h0, kill_F}, 32'd1);
    tick();
    check("exc_over_dred_pc", pc_F, 32'h0000_4180);

    // Exception beats a same-cycle eret.
    exc_req = 1'b1; eret = 1'b1; epc = 32'h0000_3050;
    #1 check("exc_eret_kill", {31'h0, kill_F}, 32'd1);
    tick();
    exc_req = 1'b0; eret = 1'b0;
    check("exc_eret_pc", pc_F, 32'h0000_4180);
    tick();
    check("seq_after_exc", pc_F, 32'h0000_4184);

    // Async reset while a redirect is pending.
    imem_ack = 1'b0; exc_req = 1'b1; epc = 32'h0000_3050; eret = 1'b0;
    d_redirect = 1'b1; d_target = 32'h0000_3400;
    tick();
    exc_req = 1'b0; d_redirect = 1'b0;
    check("pre_rst_pend", {31'h0, pend_F}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_pc", pc_F, 32'h0000_3000);
    check("async_rst_pend", {31'h0, pend_F}, 32'd0);
    check("async_rst_req", {31'h0, fetch_req}, 32'd0);
    #1 reset = 1'b0; imem_ack = 1'b1;
    tick();
    check("post_rst_seq", pc_F, 32'h0000_3004);

    // Misaligned eret target.
    eret = 1'b1; epc = 32'h0000_3002;
    tick();
    eret = 1'b0;
    check("adel_misalign_pc", pc_F, 32'h0000_3002);
    check("adel_misalign", {31'h0, adel_F}, 32'd1);
    check("adel_req", {31'h0, fetch_req}, 32'd1);

    // Aligned in-range address: no error.
    eret = 1'b1; epc = 32'h0000_3010;
    tick();
    eret = 1'b0;
    check("adel_ok", {31'h0, adel_F}, 32'd0);

    // Out-of-range but aligned: error only with the range check built in.
    eret = 1'b1; epc = 32'h0000_7000;
    tick();
    eret = 1'b0;
    check("adel_range_pc", pc_F, 32'h0000_7000);
    check("adel_range", {31'h0, adel_F}, {31'h0, range_en});

    // Sequential wrap at the top of the address space.
    eret = 1'b1; epc = 32'hFFFF_FFFC;
    tick();
    eret = 1'b0;
    check("wrap_top", pc_F, 32'hFFFF_FFFC);
    tick();
    check("wrap_zero", pc_F, 32'h0000_0000);
    check("wrap_adel", {31'h0, adel_F}, {31'h0, range_en});

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
